// File: rtl/mips32_prog_loader.sv
// Host loader for pipe_MIPS32: loads memory from a command stream, runs the core until HALTED, dumps a memory window.
// Latency: each LOAD word is written in its accept cycle; a DUMP returns one word per 3 cycles at best.
// Backpressure: in_ready is high only in IDLE/LOAD; a dump word stays on out_valid/out_data until out_ready.
module mips32_prog_loader #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_run,
  input  logic          core_halted,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RUN       = 3'd2,
    S_DUMP_RD   = 3'd3,
    S_DUMP_WAIT = 3'd4,
    S_DUMP_OUT  = 3'd5
  } state_t;

  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [13:0]   remaining;
  logic          run_first;

  logic [1:0]    hdr_cmd;
  logic [13:0]   hdr_count;
  logic [15:0]   hdr_base;
  logic          base_ok;

  assign hdr_cmd   = in_data[31:30];
  assign hdr_count = in_data[29:16];
  assign hdr_base  = in_data[15:0];
  assign base_ok   = (hdr_base >> AW) == 16'd0;

  // Memory strobes are masked by rst so an abort never lands one more access.
  assign in_ready  = !rst && (state == S_IDLE || state == S_LOAD);
  assign mem_we    = !rst && (state == S_LOAD) && in_valid;
  assign mem_re    = !rst && (state == S_DUMP_RD);
  assign mem_addr  = ptr;
  assign mem_wdata = in_data;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      run_first <= 1'b0;
      core_run  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (hdr_cmd == CMD_RUN) begin
              state     <= S_RUN;
              core_run  <= 1'b1;
              run_first <= 1'b1;
            end else if (hdr_cmd == 2'b00 || !base_ok) begin
              err <= 1'b1;
            end else if (hdr_count != 14'd0) begin
              ptr       <= hdr_base[AW-1:0];
              remaining <= hdr_count;
              state     <= (hdr_cmd == CMD_LOAD) ? S_LOAD : S_DUMP_RD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == 14'd1) state <= S_IDLE;
          end
        end
        S_RUN: begin
          // The core clears HALTED on start, so the first RUN cycle's flag is stale.
          run_first <= 1'b0;
          if (!run_first && core_halted) begin
            core_run <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DUMP_RD: state <= S_DUMP_WAIT;
        S_DUMP_WAIT: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          state     <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            state     <= (remaining == 14'd1) ? S_IDLE : S_DUMP_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: RAM and core stand-ins plus a command-level reference model of memory.
module tb_mips32_prog_loader;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MEMW = 1024;
  localparam logic [1:0] C_LOAD = 2'b01, C_RUN = 2'b10, C_DUMP = 2'b11;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          core_run;
  logic          core_halted = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy, err;

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.AW(AW), .DW(DW)) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_run(core_run), .core_halted(core_halted),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // Core memory with the loader port and a core-side write port.
  logic [31:0]   ram [0:MEMW-1];
  logic          cw_en = 1'b0;
  logic [AW-1:0] cw_addr = '0;
  logic [31:0]   cw_data = '0;
  always @(posedge clk1) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (cw_en) ram[cw_addr] <= cw_data;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  logic [31:0] ref_mem [0:MEMW-1];
  logic [41:0] wlog[$], wexp[$];
  logic [31:0] rx[$], exp_rx[$], txq[$], wq[$];
  int re_cnt = 0, viol = 0, stab_viol = 0, stall_seen = 0, stall_left = 0, bp_mode = 0;
  bit gap_en = 1'b0;

  always @(negedge clk1) begin
    #2;
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    if (mem_re) re_cnt++;
    if (mem_we && mem_re) viol++;
    if ((mem_we || mem_re) && core_run) viol++;
  end

  logic        hold_pend = 1'b0;
  logic [31:0] hold_dat = '0;
  always @(negedge clk1) begin : consumer
    logic r;
    if (hold_pend && !rst && !(out_valid === 1'b1 && out_data === hold_dat)) stab_viol++;
    r = 1'b1;
    if (bp_mode == 1) r = ($urandom_range(0, 1) == 1);
    else if (bp_mode == 2 && out_valid && rx.size() == 1 && stall_left > 0) begin
      r = 1'b0; stall_left--; stall_seen++;
    end
    out_ready = r;
    if (out_valid && r && !rst) rx.push_back(out_data);
    hold_pend = out_valid && !r && !rst;
    hold_dat  = out_data;
  end

  function automatic logic [31:0] hdr(input logic [1:0] c, input int cnt, input int base);
    return {c, cnt[13:0], base[15:0]};
  endfunction

  // Reference model: queue a LOAD of wq at base and record its memory effect.
  task automatic add_load(input int base);
    logic [AW-1:0] a;
    txq.push_back(hdr(C_LOAD, wq.size(), base));
    for (int i = 0; i < wq.size(); i++) begin
      a = AW'((base + i) % MEMW);
      txq.push_back(wq[i]);
      ref_mem[a] = wq[i];
      wexp.push_back({a, wq[i]});
    end
    wq.delete();
  endtask

  task automatic add_dump(input int base, input int n);
    txq.push_back(hdr(C_DUMP, n, base));
    for (int i = 0; i < n; i++) exp_rx.push_back(ref_mem[(base + i) % MEMW]);
  endtask

  task automatic clear_logs();
    wlog.delete(); wexp.delete(); rx.delete(); exp_rx.delete();
  endtask

  // Streams txq; returns on a negedge just after the last word transferred.
  task automatic send_stream();
    int t;
    @(negedge clk1);
    while (txq.size() > 0) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(negedge clk1); end
      in_valid = 1'b1;
      in_data  = txq.pop_front();
      t = 0;
      while (!in_ready && t < 2000) begin @(negedge clk1); t++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        in_valid = 1'b0; txq.delete(); return;
      end
      @(negedge clk1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx.size() < n && t < 2000) begin @(negedge clk1); t++; end
    if (rx.size() < n) begin
      checks++; errors++;
      $display("FAIL dump_timeout words=%0d required=%0d", rx.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk1);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL reset_core_run got=%b exp=0", core_run); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem we=%b re=%b exp=0,0", mem_we, mem_re); end
    rst = 1'b0;
    @(negedge clk1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_factorial();
    logic [31:0] prog [11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                               32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe, 32'hfc000000};
    int f, lows;
    clear_logs();
    core_halted = 1'b0;
    for (int i = 0; i < 11; i++) wq.push_back(prog[i]);
    add_load(0);
    wq.push_back(32'd7);
    add_load(200);
    txq.push_back(hdr(C_RUN, 0, 0));
    send_stream();
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL fact_run_start core_run=%b exp=1", core_run); end
    // Core stand-in computes n! of word 200 into word 198, then halts.
    lows = 0;
    repeat (10) begin @(negedge clk1); if (core_run !== 1'b1) lows++; end
    f = 1;
    for (int k = 2; k <= int'(ram[200]); k++) f = f * k;
    cw_en = 1'b1; cw_addr = AW'(198); cw_data = f;
    @(negedge clk1);
    cw_en = 1'b0;
    f = 1;
    for (int k = 2; k <= int'(ref_mem[200]); k++) f = f * k;
    ref_mem[198] = f;
    core_halted = 1'b1;
    if (core_run !== 1'b1) lows++;
    checks++; if (lows != 0) begin errors++; $display("FAIL fact_run_hold low_cycles=%0d exp=0", lows); end
    @(negedge clk1);
    checks++; if (core_run !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fact_halt_drop core_run=%b busy=%b exp=0,0", core_run, busy); end
    add_dump(198, 1);
    send_stream();
    wait_rx(1);
    checks++; if (rx.size() != 1 || rx[0] !== 32'h13B0 || rx[0] !== exp_rx[0])
      begin errors++; $display("FAIL fact_result got=%h exp=%h", rx.size() > 0 ? rx[0] : 32'hx, 32'h13B0); end
    checks++; if (wlog.size() != 12) begin errors++; $display("FAIL fact_write_count got=%0d exp=12", wlog.size()); end
    for (int i = 0; i < wlog.size() && i < wexp.size(); i++) begin
      checks++; if (wlog[i] !== wexp[i]) begin errors++; $display("FAIL fact_write[%0d] got=%h exp=%h", i, wlog[i], wexp[i]); end
    end
  endtask

  task automatic test_dump_backpressure();
    clear_logs();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    add_load(5);
    send_stream();
    checks++; if (wlog.size() != 3 || wlog[0][41:32] !== 10'd5 || wlog[2][41:32] !== 10'd7)
      begin errors++; $display("FAIL bp_preload writes=%0d exp=3 at 5..7", wlog.size()); end
    rx.delete(); exp_rx.delete();
    re_cnt = 0; stall_seen = 0; stab_viol = 0; stall_left = 4; bp_mode = 2;
    add_dump(5, 3);
    send_stream();
    wait_rx(3);
    repeat (2) @(negedge clk1);
    bp_mode = 0;
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp_rx[i]) begin errors++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, rx[i], exp_rx[i]); end
    end
    checks++; if (stall_seen != 4) begin errors++; $display("FAIL bp_stall_cycles got=%0d exp=4", stall_seen); end
    checks++; if (stab_viol != 0)  begin errors++; $display("FAIL bp_hold_stable violations=%0d exp=0", stab_viol); end
    checks++; if (re_cnt != 3)     begin errors++; $display("FAIL bp_mem_re got=%0d exp=3", re_cnt); end
  endtask

  task automatic test_wrap_zero();
    int rc;
    clear_logs();
    wq.push_back(32'd1); wq.push_back(32'd2);
    add_load(1023);
    send_stream();
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", wlog.size()); end
    else begin
      checks++; if (wlog[0] !== {10'd1023, 32'd1}) begin errors++; $display("FAIL wrap_first got=%h exp=%h", wlog[0], {10'd1023, 32'd1}); end
      checks++; if (wlog[1] !== {10'd0, 32'd2})    begin errors++; $display("FAIL wrap_second got=%h exp=%h", wlog[1], {10'd0, 32'd2}); end
    end
    rc = re_cnt;
    txq.push_back(hdr(C_LOAD, 0, 50));
    send_stream();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_load_busy got=%b exp=0", busy); end
    txq.push_back(hdr(C_DUMP, 0, 60));
    send_stream();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_dump_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk1);
    checks++; if (wlog.size() != 2 || re_cnt != rc)
      begin errors++; $display("FAIL zero_no_access writes=%0d reads=%0d exp=2,0", wlog.size(), re_cnt - rc); end
  endtask

  task automatic test_illegal();
    clear_logs();
    txq.push_back(32'h0000_0000);
    send_stream();
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_cmd err=%b busy=%b exp=1,0", err, busy); end
    txq.push_back(32'h4001_0400);
    send_stream();
    repeat (2) @(negedge clk1);
    checks++; if (wlog.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL bad_base writes=%0d busy=%b exp=0,0", wlog.size(), busy); end
    wq.push_back($urandom);
    add_load(16);
    send_stream();
    checks++; if (wlog.size() != 1 || wlog[0] !== wexp[0])
      begin errors++; $display("FAIL post_err_load writes=%0d got=%h exp=%h", wlog.size(), wlog.size() > 0 ? wlog[0] : 42'hx, wexp[0]); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] n0, n1;
    clear_logs();
    for (int i = 0; i < 5; i++) wq.push_back($urandom);
    add_load(400);
    send_stream();
    clear_logs();
    n0 = $urandom; n1 = $urandom;
    txq.push_back(hdr(C_LOAD, 5, 400)); txq.push_back(n0); txq.push_back(n1);
    ref_mem[400] = n0; ref_mem[401] = n1;
    wexp.push_back({10'd400, n0}); wexp.push_back({10'd401, n1});
    send_stream();
    rst = 1'b1; in_valid = 1'b1; in_data = $urandom;
    @(negedge clk1);
    checks++; if (busy !== 1'b0 || core_run !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL rst_load busy=%b run=%b ov=%b err=%b exp=0,0,0,0", busy, core_run, out_valid, err); end
    in_valid = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk1);
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL rst_load_writes got=%0d exp=2", wlog.size()); end
    add_dump(400, 3);
    send_stream();
    wait_rx(3);
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp_rx[i]) begin errors++; $display("FAIL rst_partial[%0d] got=%h exp=%h", i, rx[i], exp_rx[i]); end
    end
    core_halted = 1'b0;
    txq.push_back(hdr(C_RUN, 0, 0));
    send_stream();
    repeat (3) @(negedge clk1);
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL rst_run_pre core_run=%b exp=1", core_run); end
    rst = 1'b1;
    @(negedge clk1);
    checks++; if (core_run !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_run core_run=%b busy=%b exp=0,0", core_run, busy); end
    rst = 1'b0;
    @(negedge clk1);
  endtask

  task automatic test_halt_at_entry();
    int lows = 0;
    core_halted = 1'b1;
    txq.push_back(hdr(C_RUN, 0, 0));
    send_stream();
    @(negedge clk1);
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL halt_entry_ignored core_run=%b exp=1", core_run); end
    core_halted = 1'b0;
    repeat (20) begin @(negedge clk1); if (core_run !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL halt_entry_hold low_cycles=%0d exp=0", lows); end
    core_halted = 1'b1;
    @(negedge clk1);
    checks++; if (core_run !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL halt_entry_stop core_run=%b busy=%b exp=0,0", core_run, busy); end
  endtask

  task automatic test_random();
    int n, base;
    clear_logs();
    for (int i = 0; i < 48; i++) wq.push_back($urandom);
    add_load(300);
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(1, 6);
      base = 300 + $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wq.push_back($urandom);
        add_load(base);
      end else add_dump(base, n);
    end
    gap_en = 1'b1; bp_mode = 1; stab_viol = 0;
    send_stream();
    wait_rx(exp_rx.size());
    repeat (2) @(negedge clk1);
    gap_en = 1'b0; bp_mode = 0;
    checks++; if (rx.size() != exp_rx.size()) begin errors++; $display("FAIL rand_dump_count got=%0d exp=%0d", rx.size(), exp_rx.size()); end
    for (int i = 0; i < rx.size() && i < exp_rx.size(); i++) begin
      checks++; if (rx[i] !== exp_rx[i]) begin errors++; $display("FAIL rand_dump[%0d] got=%h exp=%h", i, rx[i], exp_rx[i]); end
    end
    checks++; if (wlog.size() != wexp.size()) begin errors++; $display("FAIL rand_write_count got=%0d exp=%0d", wlog.size(), wexp.size()); end
    for (int i = 0; i < wlog.size() && i < wexp.size(); i++) begin
      checks++; if (wlog[i] !== wexp[i]) begin errors++; $display("FAIL rand_write[%0d] got=%h exp=%h", i, wlog[i], wexp[i]); end
    end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_hold_stable violations=%0d exp=0", stab_viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_factorial();
    test_dump_backpressure();
    test_wrap_zero();
    test_illegal();
    test_reset_mid();
    test_halt_at_entry();
    test_random();
    checks++; if (viol != 0) begin errors++; $display("FAIL strobe_exclusive violations=%0d exp=0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
